// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg: shared state encoding, result codes and default timing for the
// AD9244 capture sequencer.
package adc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ARM     = 3'd2,
        CAPTURE = 3'd3,
        STOP    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_ARM_TO = 2'b01;
    localparam logic [1:0] ERR_OVR    = 2'b10;
    localparam logic [1:0] ERR_ABORT  = 2'b11;

    localparam int DEF_CLEAR_CYCLES = 4;
    localparam int DEF_ARM_TIMEOUT  = 1024;

    // States in which the stream may deliver beats and OTR is being watched.
    function automatic logic is_tracking(input state_t s);
        return (s == ARM) || (s == CAPTURE) || (s == STOP);
    endfunction

endpackage

// File: rtl/adc_beat_counter.sv
// adc_beat_counter: saturating count of accepted AXIS beats plus the compare
// that flags the beat completing the programmed length.
module adc_beat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_beat,
    input  logic [CNT_WIDTH-1:0] i_len,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_term
);

    localparam logic [CNT_WIDTH-1:0] ZERO     = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ALL_ONES = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] r_count;

    // Beat counter: cleared on a new capture, holds at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= ZERO;
        end else if (i_clr) begin
            r_count <= ZERO;
        end else if (i_beat && (r_count != ALL_ONES)) begin
            r_count <= r_count + ONE;
        end
    end

    // Length 0 means run until aborted, so it never terminates.
    assign o_term  = i_beat && (i_len != ZERO) && (r_count == (i_len - ONE));
    assign o_count = r_count;

endmodule

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: runs one AD9244 capture -- pulse the sticky-error clears,
// enable the stream, count accepted beats, stop and report the outcome.
module adc_capture_sequencer
    import adc_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH    = 32,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    parameter int ARM_TIMEOUT  = DEF_ARM_TIMEOUT
) (
    input  logic                 M_AXIS_ACLK,
    input  logic                 M_AXIS_ARESET,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] captureLen,
    input  logic                 testModeReq,
    input  logic                 abortOnOverRun,
    input  logic                 axisTvalid,
    input  logic                 axisTready,
    input  logic                 streamStatus,
    input  logic                 overRunStatus,
    input  logic                 adcOTRstatus,
    output logic                 streamEnable,
    output logic                 testMode,
    output logic                 clearOverRun,
    output logic                 clearOTR,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           errCode,
    output logic                 otrSeen,
    output logic [CNT_WIDTH-1:0] beatCount
);

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int ARM_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_len;
    logic                 r_abort_ovr;
    logic                 r_len_hit;
    logic [CLR_W-1:0]     r_clr_cnt;
    logic [ARM_W-1:0]     r_arm_cnt;
    logic                 r_stream_en;
    logic                 r_test_mode;
    logic                 r_clear;
    logic                 r_busy;
    logic                 r_done;
    logic [1:0]           r_err;
    logic                 r_otr;

    logic                 w_tracking;
    logic                 w_beat;
    logic                 w_cnt_clr;
    logic                 w_term;
    logic [CNT_WIDTH-1:0] w_count;

    assign w_tracking = is_tracking(r_state);
    assign w_beat     = axisTvalid && axisTready && w_tracking;
    assign w_cnt_clr  = (r_state == IDLE) && start;

    adc_beat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_beat_counter (
        .i_clk   (M_AXIS_ACLK),
        .i_rst   (M_AXIS_ARESET),
        .i_clr   (w_cnt_clr),
        .i_beat  (w_beat),
        .i_len   (r_len),
        .o_count (w_count),
        .o_term  (w_term)
    );

    // Capture sequencing FSM with all block outputs registered alongside the state.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            r_state     <= IDLE;
            r_len       <= {CNT_WIDTH{1'b0}};
            r_abort_ovr <= 1'b0;
            r_len_hit   <= 1'b0;
            r_clr_cnt   <= {CLR_W{1'b0}};
            r_arm_cnt   <= {ARM_W{1'b0}};
            r_stream_en <= 1'b0;
            r_test_mode <= 1'b0;
            r_clear     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= ERR_OK;
            r_otr       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= CLEAR;
                        r_busy      <= 1'b1;
                        r_len       <= captureLen;
                        r_abort_ovr <= abortOnOverRun;
                        r_test_mode <= testModeReq;
                        r_clear     <= 1'b1;
                        r_clr_cnt   <= {CLR_W{1'b0}};
                        r_len_hit   <= 1'b0;
                        r_err       <= ERR_OK;
                        r_otr       <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (abort) begin
                        r_state <= STOP;
                        r_clear <= 1'b0;
                        r_err   <= ERR_ABORT;
                    end else if (r_clr_cnt == CLR_LAST) begin
                        r_state     <= ARM;
                        r_clear     <= 1'b0;
                        r_stream_en <= 1'b1;
                        r_arm_cnt   <= {ARM_W{1'b0}};
                    end else begin
                        r_clr_cnt <= r_clr_cnt + CLR_W'(1);
                    end
                end
                ARM: begin
                    // A length-1 capture completes here; remember it for CAPTURE.
                    if (w_term) begin
                        r_len_hit <= 1'b1;
                    end
                    if (abort) begin
                        r_state     <= STOP;
                        r_stream_en <= 1'b0;
                        r_err       <= ERR_ABORT;
                    end else if (streamStatus) begin
                        r_state <= CAPTURE;
                    end else if (r_arm_cnt == ARM_LAST) begin
                        r_state     <= STOP;
                        r_stream_en <= 1'b0;
                        r_err       <= ERR_ARM_TO;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        r_state     <= STOP;
                        r_stream_en <= 1'b0;
                        r_err       <= ERR_ABORT;
                    end else if (overRunStatus && r_abort_ovr) begin
                        r_state     <= STOP;
                        r_stream_en <= 1'b0;
                        r_err       <= ERR_OVR;
                    end else if (w_term || r_len_hit) begin
                        r_state     <= STOP;
                        r_stream_en <= 1'b0;
                    end
                end
                STOP: begin
                    if (!streamStatus && !axisTvalid) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_test_mode <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_stream_en <= 1'b0;
                    r_clear     <= 1'b0;
                    r_busy      <= 1'b0;
                    r_test_mode <= 1'b0;
                end
            endcase
            if (w_tracking && adcOTRstatus) begin
                r_otr <= 1'b1;
            end
        end
    end

    assign streamEnable = r_stream_en;
    assign testMode     = r_test_mode;
    assign clearOverRun = r_clear;
    assign clearOTR     = r_clear;
    assign busy         = r_busy;
    assign done         = r_done;
    assign errCode      = r_err;
    assign otrSeen      = r_otr;
    assign beatCount    = w_count;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: a behavioural ADC stream stand-in, a table of
// capture scenarios, randomized captures and hand-written reset/abort sequences.
module tb_adc_capture_sequencer;
    import adc_ctrl_pkg::*;

    localparam int CW     = 32;
    localparam int BUDGET = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort;
    logic [CW-1:0] captureLen;
    logic          testModeReq, abortOnOverRun;
    logic          axisTvalid, axisTready, streamStatus, overRunStatus, adcOTRstatus;
    logic          streamEnable, testMode, clearOverRun, clearOTR, busy, done, otrSeen;
    logic [1:0]    errCode;
    logic [CW-1:0] beatCount;

    int n_tests = 0;
    int n_fail  = 0;

    // Stream model and reference-model state.
    bit hold_low, se_cycle, otr_win, cap_win, otr_exp;
    int tb_beats, done_cnt;

    typedef struct {
        string      name;
        int         len;
        bit         tmode;
        bit         aovr;
        int         rmode;     // 0 always ready, 1 random ready, 2 stall at beat 20 then overrun
        bit         hold;      // stream never comes up
        int         abort_at;  // -1 never, else cycle after start
        bit         spur;      // extra start pulses while busy
        bit         otr;       // random OTR pulses
        logic [1:0] exp_err;
        int         exp_lo;
        int         exp_hi;
        int         exp_clr;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    adc_capture_sequencer #(
        .CNT_WIDTH    (CW),
        .CLEAR_CYCLES (4),
        .ARM_TIMEOUT  (1024)
    ) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESET  (rst),
        .start          (start),
        .abort          (abort),
        .captureLen     (captureLen),
        .testModeReq    (testModeReq),
        .abortOnOverRun (abortOnOverRun),
        .axisTvalid     (axisTvalid),
        .axisTready     (axisTready),
        .streamStatus   (streamStatus),
        .overRunStatus  (overRunStatus),
        .adcOTRstatus   (adcOTRstatus),
        .streamEnable   (streamEnable),
        .testMode       (testMode),
        .clearOverRun   (clearOverRun),
        .clearOTR       (clearOTR),
        .busy           (busy),
        .done           (done),
        .errCode        (errCode),
        .otrSeen        (otrSeen),
        .beatCount      (beatCount)
    );

    function automatic vec_t mk(input string name, input int len, input bit tmode, input bit aovr,
                                input int rmode, input bit hold, input int abort_at, input bit spur,
                                input bit otr, input logic [1:0] err, input int lo, input int hi,
                                input int clr);
        vec_t v;
        v.name = name; v.len = len; v.tmode = tmode; v.aovr = aovr; v.rmode = rmode;
        v.hold = hold; v.abort_at = abort_at; v.spur = spur; v.otr = otr;
        v.exp_err = err; v.exp_lo = lo; v.exp_hi = hi; v.exp_clr = clr;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock: sample at the edge, observe outputs 1 time unit later, update the stream model.
    task automatic tick();
        bit beat_e;
        @(posedge clk);
        beat_e = axisTvalid && axisTready;
        if (beat_e && cap_win) tb_beats++;
        if (adcOTRstatus && otr_win) otr_exp = 1'b1;
        #1;
        if (streamEnable && !hold_low) begin
            streamStatus = 1'b1;
            axisTvalid   = 1'b1;
        end else if (!streamEnable && axisTvalid && beat_e && !se_cycle) begin
            // the single trailing beat after enable fell has been taken
            axisTvalid   = 1'b0;
            streamStatus = 1'b0;
        end else if (!streamEnable && !axisTvalid) begin
            streamStatus = 1'b0;
        end
        if (clearOverRun) overRunStatus = 1'b0;
        se_cycle = streamEnable;
        if (streamEnable) otr_win = 1'b1;
        if (done) begin
            otr_win = 1'b0;
            cap_win = 1'b0;
            done_cnt++;
        end
    endtask

    task automatic run_capture(input vec_t v);
        int c, clr_hi, clr_bad, se_hi, stall, ovr_c, lat, tm_bad;
        bit prev_clr, lat_done;
        c = 0; clr_hi = 0; clr_bad = 0; se_hi = 0; stall = 0; ovr_c = 0; lat = 0; tm_bad = 0;
        prev_clr = 1'b0; lat_done = 1'b0;
        tb_beats = 0; otr_exp = 1'b0; otr_win = 1'b0; cap_win = 1'b1; done_cnt = 0;
        hold_low = v.hold; overRunStatus = 1'b0; adcOTRstatus = 1'b0;
        testModeReq = v.tmode; abortOnOverRun = v.aovr;
        while (done_cnt == 0 && c < BUDGET) begin
            start      = (c == 0) || (v.spur && (c == 100 || c == 200));
            captureLen = (c == 0) ? CW'(v.len) : CW'(3);
            if (v.abort_at >= 0 && c >= v.abort_at) abort = 1'b1;
            if (v.rmode == 0) begin
                axisTready = 1'b1;
            end else if (v.rmode == 1) begin
                axisTready = ($urandom_range(0, 3) != 0);
            end else if (stall == 0 && tb_beats >= 20) begin
                stall = 1; axisTready = 1'b0;
            end else if (stall >= 1 && stall < 3) begin
                stall++; axisTready = 1'b0;
            end else if (stall == 3) begin
                stall = 4; axisTready = 1'b1; overRunStatus = 1'b1; ovr_c = c;
            end else begin
                axisTready = 1'b1;
            end
            adcOTRstatus = v.otr && ($urandom_range(0, 40) == 0);
            tick();
            c++;
            if (c == 1) check({v.name, ":busy_after_start"}, busy, 1);
            if (clearOverRun != clearOTR) clr_bad++;
            if (clearOverRun) clr_hi++;
            if (prev_clr && !clearOverRun) check({v.name, ":se_after_clear"}, streamEnable, (v.abort_at != 0));
            prev_clr = clearOverRun;
            if (streamEnable) se_hi++;
            if (busy && testMode != v.tmode) tm_bad++;
            if (stall == 4 && !lat_done && !streamEnable) begin
                lat = c - ovr_c; lat_done = 1'b1;
            end
        end
        start = 1'b0; abort = 1'b0; adcOTRstatus = 1'b0; axisTready = 1'b1;
        check({v.name, ":done_seen"}, done_cnt, 1);
        check({v.name, ":errCode"}, errCode, v.exp_err);
        check({v.name, ":beats_vs_bench"}, beatCount, tb_beats);
        check_range({v.name, ":beat_range"}, beatCount, v.exp_lo, v.exp_hi);
        check({v.name, ":clear_cycles"}, clr_hi, v.exp_clr);
        check({v.name, ":clear_pair"}, clr_bad, 0);
        check({v.name, ":testMode_held"}, tm_bad, 0);
        check({v.name, ":testMode_idle"}, testMode, 0);
        check({v.name, ":otrSeen"}, otrSeen, otr_exp);
        if (v.hold) check({v.name, ":arm_cycles"}, se_hi, 1024);
        if (v.rmode == 2 && v.aovr) check_range({v.name, ":ovr_latency"}, lat, 1, 2);
        repeat (3) tick();
        check({v.name, ":done_once"}, done_cnt, 1);
        check({v.name, ":idle_busy"}, busy, 0);
        check({v.name, ":idle_se"}, streamEnable, 0);
        check({v.name, ":err_held"}, errCode, v.exp_err);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = mk("len100",        100, 1'b1, 1'b0, 0, 1'b0,  -1, 1'b0, 1'b0, ERR_OK,     100, 101, 4);
        vecs[1] = mk("ovr_abort",      50, 1'b0, 1'b1, 2, 1'b0,  -1, 1'b0, 1'b0, ERR_OVR,     20,  22, 4);
        vecs[2] = mk("ovr_ignored",    50, 1'b0, 1'b0, 2, 1'b0,  -1, 1'b0, 1'b0, ERR_OK,      50,  51, 4);
        vecs[3] = mk("arm_timeout",    10, 1'b1, 1'b0, 0, 1'b1,  -1, 1'b0, 1'b0, ERR_ARM_TO,   0,   0, 4);
        vecs[4] = mk("cont_abort",      0, 1'b0, 1'b0, 1, 1'b0, 300, 1'b1, 1'b1, ERR_ABORT,    1, 400, 4);
        // one beat in ARM, one in the single CAPTURE cycle, one trailing beat
        vecs[5] = mk("len1",            1, 1'b0, 1'b0, 0, 1'b0,  -1, 1'b0, 1'b0, ERR_OK,       1,   3, 4);
        vecs[6] = mk("len7_rnd",        7, 1'b0, 1'b0, 1, 1'b0,  -1, 1'b0, 1'b1, ERR_OK,       7,   8, 4);
        vecs[7] = mk("abort_at_start", 20, 1'b1, 1'b0, 0, 1'b0,   0, 1'b0, 1'b0, ERR_ABORT,    0,   0, 1);

        rst = 1'b1; start = 1'b0; abort = 1'b0; captureLen = '0; testModeReq = 1'b0;
        abortOnOverRun = 1'b0; axisTvalid = 1'b0; axisTready = 1'b1; streamStatus = 1'b0;
        overRunStatus = 1'b0; adcOTRstatus = 1'b0;
        hold_low = 1'b0; se_cycle = 1'b0; otr_win = 1'b0; cap_win = 1'b0; otr_exp = 1'b0;
        tb_beats = 0; done_cnt = 0;
        repeat (2) tick();
        check("reset:busy", busy, 0);
        check("reset:se", streamEnable, 0);
        check("reset:clear", clearOverRun, 0);
        check("reset:beatCount", beatCount, 0);
        check("reset:errCode", errCode, 0);
        rst = 1'b0;
        tick();

        // Abort held in IDLE without a start does nothing.
        abort = 1'b1;
        repeat (3) tick();
        check("idle_abort:busy", busy, 0);
        check("idle_abort:clear", clearOverRun, 0);
        abort = 1'b0;

        for (int i = 0; i < 8; i++) run_capture(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            rv = mk($sformatf("rand%0d", i), $urandom_range(1, 40), 1'($urandom_range(0, 1)),
                    1'b0, 1, 1'b0, -1, 1'b0, 1'b1, ERR_OK, 0, 0, 4);
            rv.exp_lo = rv.len;
            rv.exp_hi = rv.len + 1;
            run_capture(rv);
        end

        // Reset during CAPTURE: everything clears next cycle and no done follows.
        captureLen = CW'(100); testModeReq = 1'b1; abortOnOverRun = 1'b0; hold_low = 1'b0;
        axisTready = 1'b1; cap_win = 1'b1; tb_beats = 0; done_cnt = 0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        check("mid_reset:pre_se", streamEnable, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset:se", streamEnable, 0);
        check("mid_reset:busy", busy, 0);
        check("mid_reset:testMode", testMode, 0);
        check("mid_reset:beatCount", beatCount, 0);
        check("mid_reset:done", done, 0);
        check("mid_reset:otrSeen", otrSeen, 0);
        axisTvalid = 1'b0; streamStatus = 1'b0; se_cycle = 1'b0; otr_win = 1'b0; cap_win = 1'b0;
        done_cnt = 0;
        repeat (5) tick();
        check("mid_reset:no_done", done_cnt, 0);
        run_capture(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
